div_seq_restoring: RTL
======================

Name: div_seq_restoring

Overview:
Iterative unsigned restoring divider for the datapath. It sequences one shift-subtract-restore step per clock, over WIDTH cycles.
- Holds the partial remainder register.
- Feeds the dividend bits in MSB first.
- Collects one quotient bit per step.

It sits upstream of the result consumers and provides a start/busy/done handshake for the controlling FSM.

Parameters:
- WIDTH, 8, operand width in bits for dividend, divisor, quotient and remainder.
- CNT_W, 4, width of the step counter; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only when the block is not busy.
- dividend  input  WIDTH  numerator; captured on the accepted start edge.
- divisor  input  WIDTH  denominator; captured on the accepted start edge.
- busy  output  1  high while a division is in progress.
- done  output  1  single-cycle pulse when quotient and remainder become valid.
- quotient  output  WIDTH  result quotient; held until the next accepted start.
- remainder  output  WIDTH  result remainder; held until the next accepted start.
- div_by_zero  output  1  present only with DIV_ZERO_DETECT_EN.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - The internal remainder, dividend shift and counter registers are cleared.
  - Reset has priority over every other event, including mid-RUN; an aborted division produces no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1, capture dividend into a shift register, divisor into a divisor register, clear the partial remainder, load counter=WIDTH, go to RUN, busy=1.
  - If start=0, remain in IDLE.
- RUN, one step per cycle:
  - trial = {rem, dshift[MSB]}, WIDTH+1 bits wide.
  - diff = trial - {0, div}, WIDTH+1 bits; no borrow means trial >= div.
  - No borrow: q bit = 1, rem = diff[WIDTH-1:0].
  - Borrow: q bit = 0, rem = trial[WIDTH-1:0] (restore).
  - Shift dividend left by 1; shift the q bit into the quotient accumulator LSB; decrement the counter.
  - When the counter reaches 1 at the step edge, go to DONE on that edge.
  - start is ignored throughout RUN.
- DONE, one cycle:
  - done=1, busy=0.
  - quotient and remainder outputs are loaded from the accumulators on the edge entering DONE.
  - Next edge: done=0. If start=1, perform the IDLE capture and go to RUN (back-to-back); otherwise go to IDLE.
- Latency:
  - start sampled at edge k; RUN covers edges k+1 .. k+WIDTH.
  - done is high during the cycle after edge k+WIDTH.
  - Throughput is one division per WIDTH+1 cycles.
- Outputs are stable outside DONE entry; mid-RUN accumulators are not visible on quotient/remainder.
- Width rules: all arithmetic is unsigned. Remainder < divisor always holds for divisor != 0.
- divisor=0 without the optional feature: the algorithm runs normally and yields quotient = all ones, remainder = dividend.

Optional Feature:
- Macro: DIV_ZERO_DETECT_EN.
- Defined:
  - The div_by_zero port exists.
  - On an accepted start with divisor=0, go from IDLE directly to DONE. done is high in the cycle after edge k (latency 1).
  - quotient = all ones, remainder = dividend, div_by_zero = 1.
  - div_by_zero holds until the next accepted start, which clears it.
- Not defined:
  - No div_by_zero port.
  - divisor=0 takes the full WIDTH-cycle path with the results above.

Test Plan:
- Reset then start with dividend=200, divisor=7 -> busy high for 8 cycles; done pulse at cycle 9; quotient=28, remainder=4.
- dividend=255, divisor=1 -> quotient=255, remainder=0. dividend=5, divisor=9 -> quotient=0, remainder=5.
- Start pulsed again mid-RUN with 10/3 during a 200/7 run -> ignored; result is still 28/4. Then start held through DONE with 10/3 -> back-to-back run; quotient=3, remainder=1 exactly 9 cycles later.
- rst asserted at RUN step 4 of 200/7 -> next cycle: busy=0, done=0, quotient=0, remainder=0; no done pulse follows.
- dividend=100, divisor=0:
  - Without the macro: 9-cycle latency; quotient=255, remainder=100.
  - With DIV_ZERO_DETECT_EN: done one cycle after start; div_by_zero=1; quotient=255, remainder=100. div_by_zero clears on the next start.
- Exhaustive sweep, all dividend and divisor pairs with divisor != 0 -> quotient and remainder match the reference division and modulus; done is exactly one cycle wide each time.

Source files
------------

// File: rtl/div_seq_restoring_if.sv
// ---------------------------------------------------------------------------
// div_seq_restoring_if
//
// Purpose:
//    Handshake and data bundle between a controlling FSM (master) and the
//    iterative restoring divider (slave).
//
// Signals:
//    start        master -> slave  request a division (taken only when not busy)
//    dividend     master -> slave  numerator, captured on the accepted start edge
//    divisor      master -> slave  denominator, captured on the accepted start edge
//    busy         slave -> master  high while the divider is stepping
//    done         slave -> master  one-cycle pulse when results become valid
//    quotient     slave -> master  result quotient, held until the next result
//    remainder    slave -> master  result remainder, held until the next result
//    div_by_zero  slave -> master  only when DIV_ZERO_DETECT_EN is defined
//
// Configuration macro: DIV_ZERO_DETECT_EN adds the div_by_zero flag.
// ---------------------------------------------------------------------------
interface div_seq_restoring_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
    logic             div_by_zero;
`endif

`ifdef DIV_ZERO_DETECT_EN
    // The controlling FSM drives the request and reads back the results.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // The divider consumes the request and produces the results.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
`else
    // The controlling FSM drives the request and reads back the results.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder
    );

    // The divider consumes the request and produces the results.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder
    );
`endif

endinterface : div_seq_restoring_if

// File: rtl/div_seq_restoring.sv
// ---------------------------------------------------------------------------
// div_seq_restoring
//
// Purpose:
//    Iterative unsigned restoring divider. One shift-subtract-restore step is
//    performed per clock, WIDTH steps per division. Dividend bits enter the
//    partial remainder MSB first and one quotient bit is collected per step.
//    Results are published on the edge that enters DONE and are held there
//    until the next division finishes.
//
// Ports:
//    clk     input   system clock, all state changes on the rising edge
//    rst     input   synchronous active-high reset, highest priority
//    divBus  slave modport of div_seq_restoring_if:
//              start/dividend/divisor in, busy/done/quotient/remainder out,
//              plus div_by_zero out when DIV_ZERO_DETECT_EN is defined
//
// Parameters:
//    WIDTH   operand and result width in bits (WIDTH >= 2)
//    CNT_W   step counter width, 2**CNT_W must exceed WIDTH
//
// Configuration macro:
//    DIV_ZERO_DETECT_EN  when defined, a zero divisor skips the stepping
//                        phase and finishes one cycle after start with
//                        quotient = all ones, remainder = dividend and
//                        div_by_zero raised. When undefined, a zero divisor
//                        runs the full sequence and naturally yields the
//                        same quotient and remainder.
// ---------------------------------------------------------------------------
module div_seq_restoring #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    div_seq_restoring_if.slave divBus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // -----------------------------------------------------------------------
    // State and datapath registers with their next-value wires
    // -----------------------------------------------------------------------
    state_t           r_state;
    state_t           w_stateNext;

    logic [WIDTH-1:0] r_dshift;
    logic [WIDTH-1:0] w_dshiftNext;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] w_divisorNext;
    logic [WIDTH-1:0] r_partRem;
    logic [WIDTH-1:0] w_partRemNext;
    logic [WIDTH-1:0] r_qAcc;
    logic [WIDTH-1:0] w_qAccNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;

    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] w_quotientNext;
    logic [WIDTH-1:0] r_remainder;
    logic [WIDTH-1:0] w_remainderNext;

`ifdef DIV_ZERO_DETECT_EN
    logic             r_divByZero;
    logic             w_divByZeroNext;
`endif

    // -----------------------------------------------------------------------
    // Single-step datapath wires
    // -----------------------------------------------------------------------
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic             w_qBit;
    logic [WIDTH-1:0] w_remStep;
    logic [WIDTH-1:0] w_qStep;
    logic             w_accept;
    logic             w_lastStep;

    // One restoring step. The trial value brings the next dividend bit into
    // the bottom of the partial remainder. Because the partial remainder is
    // always below a nonzero divisor, the top bit of the WIDTH+1 difference
    // is a reliable borrow flag: on borrow we keep the trial (restore),
    // otherwise we keep the difference and emit a quotient one. With a zero
    // divisor the difference equals the trial and never borrows, so the
    // sequence degenerates to quotient = all ones, remainder = dividend.
    always_comb begin
        w_trial   = {r_partRem, r_dshift[WIDTH-1]};
        w_diff    = w_trial - {1'b0, r_divisor};
        w_borrow  = w_diff[WIDTH];
        w_qBit    = ~w_borrow;
        w_remStep = w_borrow ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
        w_qStep   = (r_qAcc << 1) | {{(WIDTH-1){1'b0}}, w_qBit};
    end

    // A start is only honoured when the divider is not stepping. Accepting
    // in DONE gives back-to-back divisions with no idle bubble, which keeps
    // throughput at one result every WIDTH+1 cycles.
    always_comb begin
        w_accept   = divBus.start && ((r_state == IDLE) || (r_state == DONE));
        w_lastStep = (r_cnt == CNT_W'(1));
    end

    // Next-state and next-register logic. Every register defaults to holding
    // its value; the case statement advances the stepping sequence, and an
    // accepted start then overrides whatever the case chose so that capture
    // looks the same from IDLE and from DONE. The published quotient and
    // remainder only change on the edge into DONE, so mid-run accumulator
    // values never leak to the outputs.
    always_comb begin
        w_stateNext     = r_state;
        w_dshiftNext    = r_dshift;
        w_divisorNext   = r_divisor;
        w_partRemNext   = r_partRem;
        w_qAccNext      = r_qAcc;
        w_cntNext       = r_cnt;
        w_quotientNext  = r_quotient;
        w_remainderNext = r_remainder;
`ifdef DIV_ZERO_DETECT_EN
        w_divByZeroNext = r_divByZero;
`endif

        case (r_state)
            IDLE: begin
                w_stateNext = IDLE;
            end

            RUN: begin
                w_dshiftNext  = r_dshift << 1;
                w_partRemNext = w_remStep;
                w_qAccNext    = w_qStep;
                w_cntNext     = r_cnt - CNT_W'(1);
                if (w_lastStep) begin
                    w_stateNext     = DONE;
                    w_quotientNext  = w_qStep;
                    w_remainderNext = w_remStep;
                end
            end

            DONE: begin
                w_stateNext = IDLE;
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase

`ifdef DIV_ZERO_DETECT_EN
        // A zero divisor is answered immediately without stepping.
        if (w_accept && (divBus.divisor == '0)) begin
            w_stateNext     = DONE;
            w_quotientNext  = '1;
            w_remainderNext = divBus.dividend;
            w_divByZeroNext = 1'b1;
        end else
`endif
        if (w_accept) begin
            w_stateNext   = RUN;
            w_dshiftNext  = divBus.dividend;
            w_divisorNext = divBus.divisor;
            w_partRemNext = '0;
            w_qAccNext    = '0;
            w_cntNext     = CNT_W'(WIDTH);
`ifdef DIV_ZERO_DETECT_EN
            w_divByZeroNext = 1'b0;
`endif
        end
    end

    // State register. Reset is synchronous and beats everything else,
    // including a division in flight, so an aborted run never reaches DONE
    // and never pulses done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_dshift    <= '0;
            r_divisor   <= '0;
            r_partRem   <= '0;
            r_qAcc      <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
            r_divByZero <= 1'b0;
`endif
        end else begin
            r_state     <= w_stateNext;
            r_dshift    <= w_dshiftNext;
            r_divisor   <= w_divisorNext;
            r_partRem   <= w_partRemNext;
            r_qAcc      <= w_qAccNext;
            r_cnt       <= w_cntNext;
            r_quotient  <= w_quotientNext;
            r_remainder <= w_remainderNext;
`ifdef DIV_ZERO_DETECT_EN
            r_divByZero <= w_divByZeroNext;
`endif
        end
    end

    // Handshake outputs decode straight from the registered state, so busy
    // and done are glitch-free and done lasts exactly the one DONE cycle.
    assign divBus.busy      = (r_state == RUN);
    assign divBus.done      = (r_state == DONE);
    assign divBus.quotient  = r_quotient;
    assign divBus.remainder = r_remainder;
`ifdef DIV_ZERO_DETECT_EN
    assign divBus.div_by_zero = r_divByZero;
`endif

endmodule : div_seq_restoring
